// File: rtl/subtr_seq_pkg.sv
// subtr_sequencer shared package
// Default width and FSM state encoding
package subtr_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HAVE_A = 2'd1,
    S_CALC   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/subtr_sequencer_edge_detect.sv
// Rising-edge detector for the load button
// One-cycle pulse per low-to-high transition of i_lvl
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_lvl,
  output logic o_pulse
);

  logic r_q;

  // Previous level of the input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= i_lvl;
  end

  assign o_pulse = i_lvl & ~r_q;

endmodule

// File: rtl/subtr_sequencer.sv
// Operand capture / result stage for the 4-bit subtractor
// Optional signed overflow flag: SUBTR_SEQ_OVF_EN
module subtr_sequencer
  import subtr_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             load_btn,
  input  logic             clr,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dif_in,
  output logic [WIDTH-1:0] result,
  output logic             borrow,
  output logic             result_valid,
`ifdef SUBTR_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state
);

  state_t           r_state;
  state_t           w_next;
  logic             w_evt;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_calc;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_result;
  logic             r_borrow;
  logic             r_valid;

  edge_detect u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_lvl   (load_btn),
    .o_pulse (w_evt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and datapath enables; clr overrides load events
  always_comb begin
    w_next = r_state;
    w_ld_a = 1'b0;
    w_ld_b = 1'b0;
    w_calc = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_evt) begin
        w_ld_a = 1'b1;
        w_next = S_HAVE_A;
      end
      S_HAVE_A: if (w_evt) begin
        w_ld_b = 1'b1;
        w_next = S_CALC;
      end
      S_CALC: begin
        w_calc = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: if (w_evt) begin
        w_ld_a = 1'b1;
        w_next = S_HAVE_A;
      end
    endcase
    if (clr) w_next = S_IDLE;
  end

  // Operand and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_valid  <= 1'b0;
    end else if (clr) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_borrow <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_ld_a) begin
        r_op_a  <= sw;
        r_valid <= 1'b0;
      end
      if (w_ld_b) r_op_b <= sw;
      if (w_calc) begin
        r_result <= dif_in;
        r_borrow <= (r_op_a < r_op_b);
        r_valid  <= 1'b1;
      end
    end
  end

`ifdef SUBTR_SEQ_OVF_EN
  logic r_ovf;

  // Signed overflow: operand signs differ and result sign flips from A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (clr)    r_ovf <= 1'b0;
    else if (w_calc) r_ovf <= (r_op_a[WIDTH-1] != r_op_b[WIDTH-1]) &
                              (dif_in[WIDTH-1] != r_op_a[WIDTH-1]);
  end

  assign ovf = r_ovf;
`endif

  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign result       = r_result;
  assign borrow       = r_borrow;
  assign result_valid = r_valid;
  assign state        = r_state;

endmodule

// File: tb/tb_subtr_sequencer.sv
// Directed bench for subtr_sequencer
// Scoreboard of expected results; also exercises SUBTR_SEQ_OVF_EN
module tb_subtr_sequencer;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] res;
    logic         brw;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         load_btn = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] dif_in;
  logic [W-1:0] result;
  logic         borrow;
  logic         result_valid;
  logic [1:0]   state;
`ifdef SUBTR_SEQ_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // External combinational subtractor
  assign dif_in = op_a - op_b;

  subtr_sequencer #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .load_btn     (load_btn),
    .clr          (clr),
    .op_a         (op_a),
    .op_b         (op_b),
    .dif_in       (dif_in),
    .result       (result),
    .borrow       (borrow),
    .result_valid (result_valid),
`ifdef SUBTR_SEQ_OVF_EN
    .ovf          (ovf),
`endif
    .state        (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [W-1:0] v);
    sw = v;
    load_btn = 1'b1;
    tick();
    load_btn = 1'b0;
    tick();
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    exp_t got;
    int   n;
    press(a);
    check("a_state", state, 1);
    check("a_opa", op_a, a);
    check("a_valid", result_valid, 0);
    e.res = W'(a - b);
    e.brw = (a < b);
    e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    sb.push_back(e);
    press(b);
    check("b_opb", op_b, b);
    n = 0;
    while (!result_valid && n < 5) begin
      tick();
      n++;
    end
    if (!result_valid) begin
      check("valid_timeout", result_valid, 1);
      void'(sb.pop_front());
    end else begin
      got = sb.pop_front();
      check("res", result, got.res);
      check("borrow", borrow, got.brw);
      check("done_state", state, 3);
`ifdef SUBTR_SEQ_OVF_EN
      check("ovf", ovf, got.ovf);
`endif
    end
  endtask

  initial begin
    #12;
    check("rst_state", state, 0);
    check("rst_opa", op_a, 0);
    check("rst_res", result, 0);
    check("rst_valid", result_valid, 0);
    rst_n = 1'b1;
    tick();

    run_op(4'd7, 4'd3);
    run_op(4'd3, 4'd5);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_done_valid", result_valid, 0);
    check("clr_done_res", result, 0);
    check("clr_done_state", state, 0);

    sw = 4'd9;
    load_btn = 1'b1;
    repeat (10) tick();
    check("held_state", state, 1);
    check("held_opa", op_a, 9);
    check("held_opb", op_b, 0);
    load_btn = 1'b0;
    tick();

    sw = 4'd4;
    load_btn = 1'b1;
    clr = 1'b1;
    tick();
    check("prio_state", state, 0);
    check("prio_opa", op_a, 0);
    check("prio_opb", op_b, 0);
    check("prio_valid", result_valid, 0);
    clr = 1'b0;
    load_btn = 1'b0;
    tick();

    press(4'd8);
    sw = 4'd2;
    load_btn = 1'b1;
    tick();
    check("calc_state", state, 2);
    load_btn = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_opa", op_a, 0);
    check("arst_opb", op_b, 0);
    check("arst_res", result, 0);
    check("arst_valid", result_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(4'd6, 4'd2);

`ifdef SUBTR_SEQ_OVF_EN
    run_op(4'd7, 4'd15);
    run_op(4'd5, 4'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
